scaled_bg_renderer: RTL and testbench

Parametrised full-screen background renderer for the VGA path. It maps each (DrawX, DrawY) pixel onto an IMG_W x IMG_H indexed image held in an external synchronous ROM, and performs the scaling with incremental DDA counters instead of multiply/divide. It also supports per-frame wrap-around scrolling and a transparency key, so tank and sprite layers can be composited above it. It drives the ROM address, takes the palette lookup externally, and emits registered RGB aligned with a delayed blank.

---
 rtl/scaled_bg_renderer.sv | 197 +++++++++++++++++++
 tb/tb_scaled_bg_renderer.sv | 256 +++++++++++++++++++++++++
 2 files changed

// File: rtl/scaled_bg_renderer.sv
// Full-screen scaled background renderer.
// Maps (DrawX, DrawY) onto an IMG_W x IMG_H indexed image through incremental
// DDA counters, applies per-frame wrap-around scrolling, drives a synchronous
// ROM, and registers the palette colour with a transparency key.
module scaled_bg_renderer #(
  parameter int                 IMG_W       = 32,
  parameter int                 IMG_H       = 32,
  parameter int                 SCREEN_W    = 640,
  parameter int                 SCREEN_H    = 480,
  parameter int                 ROM_LATENCY = 1,
  parameter int                 INDEX_W     = 8,
  parameter logic [INDEX_W-1:0] KEY_INDEX   = '0,
  parameter bit                 KEY_EN      = 1'b1,
  localparam int UW = (IMG_W > 1) ? $clog2(IMG_W) : 1,
  localparam int VW = (IMG_H > 1) ? $clog2(IMG_H) : 1,
  localparam int AW = (IMG_W * IMG_H > 1) ? $clog2(IMG_W * IMG_H) : 1
) (
  input  logic               vga_clk,
  input  logic               reset_n,
  input  logic [9:0]         DrawX,
  input  logic [9:0]         DrawY,
  input  logic               blank,
  input  logic [UW-1:0]      scroll_x,
  input  logic [VW-1:0]      scroll_y,
  output logic [AW-1:0]      rom_address,
  input  logic [INDEX_W-1:0] rom_q,
  output logic [INDEX_W-1:0] pal_index,
  input  logic [3:0]         pal_red,
  input  logic [3:0]         pal_green,
  input  logic [3:0]         pal_blue,
  output logic [3:0]         red,
  output logic [3:0]         green,
  output logic [3:0]         blue,
  output logic               opaque
);

  // Accumulators hold values below the screen size; one extra bit holds acc+step.
  localparam int XAW = $clog2(SCREEN_W) + 1;
  localparam int YAW = $clog2(SCREEN_H) + 1;
  // Depth of the blank/synced delay line ahead of the output register.
  localparam int DD  = ROM_LATENCY + 1;

  localparam logic [9:0]     SCR_W      = 10'(SCREEN_W);
  localparam logic [9:0]     SCR_H      = 10'(SCREEN_H);
  localparam logic [XAW-1:0] XA_STEP    = XAW'(IMG_W);
  localparam logic [XAW-1:0] XA_WRAP    = XAW'(SCREEN_W);
  localparam logic [YAW-1:0] YA_STEP    = YAW'(IMG_H);
  localparam logic [YAW-1:0] YA_WRAP    = YAW'(SCREEN_H);
  localparam logic [UW-1:0]  U_MAX      = UW'(IMG_W - 1);
  localparam logic [VW-1:0]  V_MAX      = VW'(IMG_H - 1);
  localparam logic [UW:0]    U_WRAP     = (UW + 1)'(IMG_W);
  localparam logic [VW:0]    V_WRAP     = (VW + 1)'(IMG_H);
  localparam logic [AW-1:0]  ROW_STRIDE = AW'(IMG_W);

  // DDA and scroll state
  logic [UW-1:0]  u, u_n;
  logic [XAW-1:0] x_acc, x_acc_n, x_sum;
  logic [VW-1:0]  v, v_n;
  logic [YAW-1:0] y_acc, y_acc_n, y_sum;
  logic [9:0]     last_y, last_y_n;
  logic [UW-1:0]  sx_r, sx_n;
  logic [VW-1:0]  sy_r, sy_n;
  logic           synced, synced_n;
  logic           frame_start;

  // Texel lookup
  logic [UW:0]    tu_sum;
  logic [VW:0]    tv_sum;
  logic [UW-1:0]  tu;
  logic [VW-1:0]  tv;
  logic [AW-1:0]  addr_n;

  // Pipeline and output
  logic [DD-1:0]  blank_d;
  logic [DD-1:0]  synced_d;
  logic           keyed;
  logic           show;
  logic [3:0]     red_n, green_n, blue_n;

  assign frame_start = (DrawX == '0) && (DrawY == '0);
  assign pal_index   = rom_q;

  // Horizontal DDA: u = floor(DrawX*IMG_W/SCREEN_W), clamped past the visible line
  always_comb begin
    u_n     = u;
    x_acc_n = x_acc;
    x_sum   = x_acc + XA_STEP;
    if (DrawX == '0) begin
      u_n     = '0;
      x_acc_n = '0;
    end else if (DrawX >= SCR_W) begin
      u_n = U_MAX;
    end else if (x_sum >= XA_WRAP) begin
      x_acc_n = x_sum - XA_WRAP;
      u_n     = u + UW'(1);
    end else begin
      x_acc_n = x_sum;
    end
  end

  // Vertical DDA: steps once per new line, only at the start of each line
  always_comb begin
    v_n      = v;
    y_acc_n  = y_acc;
    last_y_n = last_y;
    y_sum    = y_acc + YA_STEP;
    if (DrawX == '0) begin
      last_y_n = DrawY;
      if (DrawY == '0) begin
        v_n     = '0;
        y_acc_n = '0;
      end else if (DrawY >= SCR_H) begin
        v_n = V_MAX;
      end else if (DrawY != last_y) begin
        if (y_sum >= YA_WRAP) begin
          y_acc_n = y_sum - YA_WRAP;
          v_n     = v + VW'(1);
        end else begin
          y_acc_n = y_sum;
        end
      end
    end
  end

  // Scroll latch and wrap-around; the scroll captured at frame start is used by that same pixel
  always_comb begin
    sx_n     = frame_start ? scroll_x : sx_r;
    sy_n     = frame_start ? scroll_y : sy_r;
    synced_n = frame_start | synced;
    tu_sum   = {1'b0, u_n} + {1'b0, sx_n};
    tv_sum   = {1'b0, v_n} + {1'b0, sy_n};
    tu       = (tu_sum >= U_WRAP) ? UW'(tu_sum - U_WRAP) : UW'(tu_sum);
    tv       = (tv_sum >= V_WRAP) ? VW'(tv_sum - V_WRAP) : VW'(tv_sum);
    addr_n   = AW'(tv) * ROW_STRIDE + AW'(tu);
  end

  // DDA, scroll and ROM address registers
  always_ff @(posedge vga_clk or negedge reset_n) begin
    if (!reset_n) begin
      u           <= '0;
      x_acc       <= '0;
      v           <= '0;
      y_acc       <= '0;
      last_y      <= '0;
      sx_r        <= '0;
      sy_r        <= '0;
      synced      <= 1'b0;
      rom_address <= '0;
    end else begin
      u           <= u_n;
      x_acc       <= x_acc_n;
      v           <= v_n;
      y_acc       <= y_acc_n;
      last_y      <= last_y_n;
      sx_r        <= sx_n;
      sy_r        <= sy_n;
      synced      <= synced_n;
      rom_address <= addr_n;
    end
  end

  // Delay blank and synced so they meet rom_q at the output register
  always_ff @(posedge vga_clk or negedge reset_n) begin
    if (!reset_n) begin
      blank_d  <= '0;
      synced_d <= '0;
    end else begin
      blank_d  <= {blank_d[DD-2:0], blank};
      synced_d <= {synced_d[DD-2:0], synced_n};
    end
  end

  // Select palette colour or transparent black for this pixel
  always_comb begin
    keyed   = KEY_EN && (rom_q == KEY_INDEX);
    show    = blank_d[DD-1] && synced_d[DD-1] && !keyed;
    red_n   = show ? pal_red   : 4'h0;
    green_n = show ? pal_green : 4'h0;
    blue_n  = show ? pal_blue  : 4'h0;
  end

  // Registered pixel colour and opacity
  always_ff @(posedge vga_clk or negedge reset_n) begin
    if (!reset_n) begin
      red    <= '0;
      green  <= '0;
      blue   <= '0;
      opaque <= 1'b0;
    end else begin
      red    <= red_n;
      green  <= green_n;
      blue   <= blue_n;
      opaque <= show;
    end
  end

endmodule

// File: tb/tb_scaled_bg_renderer.sv
// Bench for scaled_bg_renderer: two instances (default 32x32 with ROM latency 1
// and keying, 40x30 with ROM latency 2 and keying off) share the raster inputs.
module tb_scaled_bg_renderer;

  logic       vga_clk = 1'b0;
  logic       reset_n;
  logic [9:0] DrawX, DrawY;
  logic       blank;
  logic [4:0] scroll_x1, scroll_y1;
  logic [5:0] scroll_x2;
  logic [4:0] scroll_y2;

  logic [9:0]  rom_address1;
  logic [10:0] rom_address2;
  logic [7:0]  rom_q1 = '0, rom_q2 = '0, rq2_a = '0;
  logic [7:0]  pal_index1, pal_index2;
  logic [3:0]  pal_red1, pal_green1, pal_blue1, pal_red2, pal_green2, pal_blue2;
  logic [3:0]  red1, green1, blue1, red2, green2, blue2;
  logic        opaque1, opaque2;

  logic [7:0] rom1 [1024];
  logic [7:0] rom2 [2048];

  int checks = 0;
  int errors = 0;

  always #5 vga_clk = ~vga_clk;

  // Palette: index 5 -> FFF, index 0 -> AFA
  function automatic logic [11:0] pal(input logic [7:0] i);
    return {i[3:0] ^ 4'hA, i[7:4] ^ 4'hF, 4'(i[3:0] + i[7:4] + 4'hA)};
  endfunction

  assign {pal_red1, pal_green1, pal_blue1} = pal(pal_index1);
  assign {pal_red2, pal_green2, pal_blue2} = pal(pal_index2);

  // Synchronous ROMs of latency 1 and 2
  always @(posedge vga_clk) begin
    rom_q1 <= rom1[rom_address1];
    rq2_a  <= rom2[rom_address2];
    rom_q2 <= rq2_a;
  end

  scaled_bg_renderer #(.ROM_LATENCY(1)) dut1 (
    .vga_clk(vga_clk), .reset_n(reset_n), .DrawX(DrawX), .DrawY(DrawY), .blank(blank),
    .scroll_x(scroll_x1), .scroll_y(scroll_y1), .rom_address(rom_address1), .rom_q(rom_q1),
    .pal_index(pal_index1), .pal_red(pal_red1), .pal_green(pal_green1), .pal_blue(pal_blue1),
    .red(red1), .green(green1), .blue(blue1), .opaque(opaque1));

  scaled_bg_renderer #(.IMG_W(40), .IMG_H(30), .ROM_LATENCY(2), .KEY_EN(1'b0)) dut2 (
    .vga_clk(vga_clk), .reset_n(reset_n), .DrawX(DrawX), .DrawY(DrawY), .blank(blank),
    .scroll_x(scroll_x2), .scroll_y(scroll_y2), .rom_address(rom_address2), .rom_q(rom_q2),
    .pal_index(pal_index2), .pal_red(pal_red2), .pal_green(pal_green2), .pal_blue(pal_blue2),
    .red(red2), .green(green2), .blue(blue2), .opaque(opaque2));

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  // Reference mapping: plain scaling arithmetic plus modular wrap
  function automatic int maddr(input int x, input int y, input int sx, input int sy,
                               input int w, input int h);
    int uu, vv;
    uu = (x >= 640) ? w - 1 : (x * w) / 640;
    vv = (y >= 480) ? h - 1 : (y * h) / 480;
    return ((vv + sy) % h) * w + ((uu + sx) % w);
  endfunction

  typedef struct {
    bit          chk;
    logic [9:0]  a1;
    logic [10:0] a2;
    logic [12:0] o1;
    logic [12:0] o2;
  } rec_t;

  rec_t hist [16];

  // Model update at each sampling edge, then compare DUT outputs just after it
  initial begin
    rec_t r;
    int   k = 0;
    int   last_rst = -100;
    int   idx;
    bit   syn = 0;
    int   msx1 = 0, msy1 = 0, msx2 = 0, msy2 = 0;
    logic [12:0] e1, e2;
    forever begin
      @(posedge vga_clk);
      r = '{chk: 1'b0, a1: '0, a2: '0, o1: '0, o2: '0};
      if (!reset_n) begin
        syn      = 0;
        last_rst = k;
      end else begin
        if (DrawX == 0 && DrawY == 0) begin
          syn  = 1;
          msx1 = int'(scroll_x1); msy1 = int'(scroll_y1);
          msx2 = int'(scroll_x2); msy2 = int'(scroll_y2);
        end
        r.chk = syn;
        r.a1  = 10'(maddr(int'(DrawX), int'(DrawY), msx1, msy1, 32, 32));
        r.a2  = 11'(maddr(int'(DrawX), int'(DrawY), msx2, msy2, 40, 30));
        if (blank && syn && rom1[r.a1] != 8'h00) r.o1 = {1'b1, pal(rom1[r.a1])};
        if (blank && syn)                        r.o2 = {1'b1, pal(rom2[r.a2])};
      end
      hist[k % 16] = r;
      #1;
      if (!reset_n) begin
        chk("rst_addr1", 32'(rom_address1), 32'h0);
        chk("rst_addr2", 32'(rom_address2), 32'h0);
        chk("rst_out1", 32'({opaque1, red1, green1, blue1}), 32'h0);
        chk("rst_out2", 32'({opaque2, red2, green2, blue2}), 32'h0);
      end else begin
        if (r.chk) begin
          chk("addr1", 32'(rom_address1), 32'(r.a1));
          chk("addr2", 32'(rom_address2), 32'(r.a2));
        end
        idx = k - 2;
        e1  = (idx <= last_rst) ? 13'h0 : hist[idx % 16].o1;
        idx = k - 3;
        e2  = (idx <= last_rst) ? 13'h0 : hist[idx % 16].o2;
        chk("out1", 32'({opaque1, red1, green1, blue1}), 32'(e1));
        chk("out2", 32'({opaque2, red2, green2, blue2}), 32'(e2));
      end
      k++;
    end
  end

  // One pixel: drive at the falling edge, return just after the sampling edge
  task automatic px(input int x, input int y, input logic b);
    @(negedge vga_clk);
    DrawX = 10'(x);
    DrawY = 10'(y);
    blank = b;
    @(posedge vga_clk);
    #2;
  endtask

  // Hand-computed expectations at specific raster positions
  task automatic directed(input int f, input int x, input int y);
    if (f == 0 && y == 0) begin
      if (x == 15) chk("u40_x15", 32'(rom_address2), 32'd0);
      if (x == 16) chk("u40_x16", 32'(rom_address2), 32'd1);
      if (x == 19) chk("addr_x19", 32'(rom_address1), 32'd0);
      if (x == 20) chk("addr_x20", 32'(rom_address1), 32'd1);
      if (x == 639) chk("addr_x639", 32'(rom_address1), 32'd31);
      if (x == 700) chk("addr_x700", 32'(rom_address1), 32'd31);
      if (x == 2) chk("first_px1", 32'({opaque1, red1, green1, blue1}), 32'h1FFF);
      if (x == 3) chk("first_px2", 32'({opaque2, red2, green2, blue2}), 32'h1FFF);
      if (x == 22) chk("key_pulse1", 32'({opaque1, red1, green1, blue1}), 32'h0);
      if (x == 22) chk("pulse2_early", 32'(opaque2), 32'h0);
      if (x == 23) chk("nokey_pulse2", 32'({opaque2, red2, green2, blue2}), 32'h1AFA);
      if (x == 24) chk("pulse2_late", 32'(opaque2), 32'h0);
      if (x == 41) chk("pulse1_early", 32'(opaque1), 32'h0);
      if (x == 42) chk("pulse1", 32'({opaque1, red1, green1, blue1}), 32'h1FFF);
      if (x == 42) chk("pulse2_early_b", 32'(opaque2), 32'h0);
      if (x == 43) chk("pulse1_late", 32'(opaque1), 32'h0);
      if (x == 43) chk("pulse2", 32'({opaque2, red2, green2, blue2}), 32'h1FFF);
      if (x == 44) chk("pulse2_late_b", 32'(opaque2), 32'h0);
    end
    if (f == 0 && x == 0 && y == 14) chk("addr_y14", 32'(rom_address1), 32'd0);
    if (f == 0 && x == 0 && y == 15) chk("addr_y15", 32'(rom_address1), 32'd32);
    if (f == 0 && x == 0 && y == 479) chk("v40_y479", 32'(rom_address2), 32'd1160);
    if (f == 0 && x == 639 && y == 479) begin
      chk("addr_last1", 32'(rom_address1), 32'd1023);
      chk("addr_last2", 32'(rom_address2), 32'd1199);
    end
    if (f == 1 && y == 0 && x == 0) begin
      chk("scroll_00_1", 32'(rom_address1), 32'd63);
      chk("scroll_00_2", 32'(rom_address2), 32'd79);
    end
    if (f == 1 && y == 0 && x == 20) begin
      chk("scroll_wrap1", 32'(rom_address1), 32'd32);
      chk("scroll_wrap2", 32'(rom_address2), 32'd40);
    end
    if (f == 1 && y == 479 && x == 639) begin
      chk("scroll_held1", 32'(rom_address1), 32'd30);
      chk("scroll_held2", 32'(rom_address2), 32'd38);
    end
  endtask

  task automatic frame(input int f);
    int   len;
    bit   full;
    logic b;
    for (int y = 0; y < 525; y++) begin
      full = (y == 0 || y == 14 || y == 15 || y == 100 || y == 200 || y == 479 ||
              y == 480 || $urandom_range(0, 127) == 0);
      len  = full ? 701 : 1 + int'($urandom_range(0, 19));
      for (int x = 0; x < len; x++) begin
        b = (x < 640 && y < 480) && ($urandom_range(0, 7) != 0);
        if (f == 0 && y == 0 && x < 64) b = (x < 4 || x == 20 || x == 40);
        if (x == 0 && y == 0) begin
          case (f)
            0: begin scroll_x1 = 0; scroll_y1 = 0; scroll_x2 = 0; scroll_y2 = 0; end
            1: begin scroll_x1 = 31; scroll_y1 = 1; scroll_x2 = 39; scroll_y2 = 1; end
            default: begin
              scroll_x1 = 5'($urandom_range(0, 31)); scroll_y1 = 5'($urandom_range(0, 31));
              scroll_x2 = 6'($urandom_range(0, 39)); scroll_y2 = 5'($urandom_range(0, 29));
            end
          endcase
        end else if (f >= 2 && ((y == 240 && x == 0) || $urandom_range(0, 2999) == 0)) begin
          scroll_x1 = 5'($urandom_range(0, 31)); scroll_y1 = 5'($urandom_range(0, 31));
          scroll_x2 = 6'($urandom_range(0, 39)); scroll_y2 = 5'($urandom_range(0, 29));
        end
        if (f == 1 && y == 100 && x == 0) begin
          scroll_x1 = 0;
          scroll_x2 = 0;
        end
        if (f == 3 && y == 200) reset_n = !(x >= 5 && x < 8);
        px(x, y, b);
        directed(f, x, y);
      end
    end
  endtask

  initial begin
    reset_n = 1'b0;
    DrawX = 10'd100; DrawY = 10'd50; blank = 1'b1;
    scroll_x1 = 0; scroll_y1 = 0; scroll_x2 = 0; scroll_y2 = 0;
    for (int i = 0; i < 1024; i++)
      rom1[i] = ($urandom_range(0, 5) == 0) ? 8'h00 : 8'($urandom);
    for (int i = 0; i < 2048; i++)
      rom2[i] = ($urandom_range(0, 5) == 0) ? 8'h00 : 8'($urandom);
    rom1[0] = 8'd5; rom1[1] = 8'd0; rom1[2] = 8'd5;
    rom2[0] = 8'd5; rom2[1] = 8'd0; rom2[2] = 8'd5;

    // Reset mid-line, then run unsynced to the end of the frame
    for (int x = 100; x < 700; x++) begin
      if (x == 110) reset_n = 1'b1;
      px(x, 50, x < 640);
      if (x == 200) begin
        chk("unsynced1", 32'({opaque1, red1}), 32'h0);
        chk("unsynced2", 32'({opaque2, red2}), 32'h0);
      end
    end
    for (int y = 51; y < 525; y++) begin
      int len;
      len = 1 + int'($urandom_range(0, 19));
      for (int x = 0; x < len; x++)
        px(x, y, (y < 480) && ($urandom_range(0, 3) != 0));
    end

    for (int f = 0; f < 5; f++) frame(f);
    px(0, 0, 1'b0);
    px(1, 0, 1'b0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
